note_seq_pwm: RTL
=================

// Module: note_seq_pwm
// PURPOSE
//  Multi-voice successor to the single-tone player: buffers note frames (channel, pitch, duration) in a FIFO,
//  dispatches them in order to CHANNELS square-wave voices, and mixes the voices into one PWM audio output.
//  Sits between the SPI note receiver (upstream, valid/ready) and the speaker pin; one clock domain.
// PARAMETERS
//  CHANNELS    2   number of voices; power of two, 1..8
//  FIFO_DEPTH  8   note frames buffered; >= 2
//  PITCH_W     16  width of note_pitch (half-period in clk cycles; 0 = rest)
//  DUR_W       16  width of note_dur (duration in tick pulses)
//  PWM_W       8   PWM carrier counter width; carrier period 2^PWM_W clk; PWM_W >= log2(CHANNELS)
// PORTS
//  clk         in   1              system clock, all logic on rising edge
//  reset       in   1              synchronous, active-high
//  enable      in   1              1 = play; 0 = pause (FIFO still accepts)
//  tick        in   1              1-clk duration time-base strobe
//  note_valid  in   1              frame present
//  note_ready  out  1              FIFO can accept; transfer when valid && ready
//  note_ch     in   max(1,clog2(CHANNELS))  target voice
//  note_pitch  in   PITCH_W        half-period in clk cycles
//  note_dur    in   DUR_W          duration in ticks
//  playing     out  CHANNELS       per-voice active flag
//  busy        out  1              FIFO non-empty or any voice active
//  pwm         out  1              mixed PWM audio
// BEHAVIOUR
//  Reset: FIFO empty, all voices idle, square bits 0, PWM counter 0, pwm=0, playing=0, busy=0, note_ready=0
//   during the reset cycle, 1 from the first cycle after. Reset mid-note aborts everything at that edge.
//  FIFO: note_ready = !full (registered count). Push on valid&&ready. Full: push refused, no overwrite.
//   Push and pop in the same cycle allowed when non-empty; count unchanged. Pointers wrap at FIFO_DEPTH.
//  Dispatch (max one pop/cycle): pop head when !empty && enable && voice[head.ch] idle. Strict order:
//   head blocked on a busy voice stalls all later frames (head-of-line). Latency: frame pushed at edge N
//   is poppable at edge N+1; voice playing=1 from edge N+1.
//   note_dur=0: frame popped, voice stays idle (no-op).
//  Voice states IDLE -> PLAY (on dispatch) -> IDLE (duration exhausted):
//   PLAY load: tone_cnt=pitch-1, dur_cnt=note_dur, sq=0.
//   Tone: each enabled cycle tone_cnt decrements; at 0 sq toggles and tone_cnt reloads pitch-1
//   -> square period 2*pitch clk. pitch=0 (rest): sq held 0, duration still counts. pitch=1: sq toggles every clk.
//   Duration: dur_cnt decrements on tick && enable; tick with dur_cnt==1 -> IDLE at that edge, sq=0.
//   A voice going idle at edge K can accept its next frame at edge K+1 (idle status registered).
//  enable=0: tone_cnt, dur_cnt, PWM counter hold; ticks ignored; no dispatch; pwm forced 0.
//  Mix: level = popcount(sq) in 0..CHANNELS; threshold (PWM_W+1 bits) = level << (PWM_W - log2 CHANNELS);
//   threshold latched when PWM counter == 2^PWM_W-1 (glitch-free period boundary).
//   pwm registered = (pwm_cnt < threshold_latched): all voices high -> pwm constantly 1; none -> 0.
//  busy = !empty || |playing.
// TESTING (CHANNELS=2, FIFO_DEPTH=8, PWM_W=4, tick every 100 clk)
//  Single note ch0 pitch=5 dur=3 -> playing[0] high ~300 clk, sq period 10 clk, pwm duty 8/16 while sq=1, 0 else.
//  ch0 pitch=4 + ch1 pitch=6 overlapping -> pwm duty steps among 0, 8/16, 16/16 per latched level.
//  enable=0, push 9 frames -> note_ready low after 8th, 9th held; enable=1 -> 8 frames play in push order.
//  ch0 dur=5, ch0 dur=1, ch1 dur=1 -> ch1 frame starts only after first ch0 note ends (head-of-line).
//  dur=0 frame -> popped, playing stays 0; pitch=0 dur=2 -> playing high 2 ticks, pwm stays 0.
//  Reset asserted mid-note with 3 frames queued -> next cycle playing=0, pwm=0, busy=0, FIFO empty.

Source files
------------

// File: rtl/note_seq_pwm.sv
// Note-frame FIFO feeding CHANNELS square-wave voices mixed into one registered PWM pin; frames pop one edge
// after push at the earliest, in strict order (a head frame for a busy voice stalls the queue); note_ready = FIFO not full.
module note_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_rdy  = (count != CNT_W'(DEPTH));
  assign out_vld = (count != '0);
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module note_seq_pwm #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int PITCH_W    = 16,
  parameter int DUR_W      = 16,
  parameter int PWM_W      = 8
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic                                             tick,
  input  logic                                             note_valid,
  output logic                                             note_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] note_ch,
  input  logic [PITCH_W-1:0]                               note_pitch,
  input  logic [DUR_W-1:0]                                 note_dur,
  output logic [CHANNELS-1:0]                              playing,
  output logic                                             busy,
  output logic                                             pwm
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LOG2CH = $clog2(CHANNELS);
  localparam int LVL_W  = $clog2(CHANNELS + 1);
  localparam int THR_W  = PWM_W + 1;
  localparam int SHIFT  = PWM_W - LOG2CH;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [PITCH_W-1:0] pitch;
    logic [DUR_W-1:0]   dur;
  } frame_t;

  localparam int FRAME_W = $bits(frame_t);

  typedef enum logic {V_IDLE, V_PLAY} vstate_t;

  frame_t             in_frame;
  frame_t             head;
  logic [FRAME_W-1:0] head_dat;
  logic               fifo_in_rdy;
  logic               fifo_out_vld;
  logic               fifo_out_rdy;
  logic               pop;
  logic [CH_W-1:0]    head_ch;

  vstate_t            vstate      [CHANNELS];
  vstate_t            vstate_nx   [CHANNELS];
  logic [PITCH_W-1:0] vpitch      [CHANNELS];
  logic [PITCH_W-1:0] vpitch_nx   [CHANNELS];
  logic [PITCH_W-1:0] tone_cnt    [CHANNELS];
  logic [PITCH_W-1:0] tone_cnt_nx [CHANNELS];
  logic [DUR_W-1:0]   dur_cnt     [CHANNELS];
  logic [DUR_W-1:0]   dur_cnt_nx  [CHANNELS];
  logic [CHANNELS-1:0] sq;
  logic [CHANNELS-1:0] sq_nx;

  logic [LVL_W-1:0]   level;
  logic [THR_W-1:0]   thr;
  logic [THR_W-1:0]   thr_q;
  logic [PWM_W-1:0]   pwm_cnt;

  assign in_frame = '{ch: note_ch, pitch: note_pitch, dur: note_dur};

  note_seq_fifo #(
    .WIDTH(FRAME_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (note_valid),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (in_frame),
    .out_vld (fifo_out_vld),
    .out_rdy (fifo_out_rdy),
    .out_dat (head_dat)
  );

  assign note_ready   = fifo_in_rdy && !reset;
  assign head         = frame_t'(head_dat);
  assign head_ch      = (CHANNELS > 1) ? head.ch : '0;
  assign fifo_out_rdy = enable && (vstate[head_ch] == V_IDLE);
  assign pop          = fifo_out_vld && fifo_out_rdy;

  // Voice next-state: load on dispatch (zero-duration frames are dropped), then tone and duration countdowns.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      vstate_nx[c]   = vstate[c];
      vpitch_nx[c]   = vpitch[c];
      tone_cnt_nx[c] = tone_cnt[c];
      dur_cnt_nx[c]  = dur_cnt[c];
      sq_nx[c]       = sq[c];
      case (vstate[c])
        V_IDLE: begin
          if (pop && (head_ch == CH_W'(c)) && (head.dur != '0)) begin
            vstate_nx[c]   = V_PLAY;
            vpitch_nx[c]   = head.pitch;
            tone_cnt_nx[c] = head.pitch - 1'b1;
            dur_cnt_nx[c]  = head.dur;
            sq_nx[c]       = 1'b0;
          end
        end
        V_PLAY: begin
          if (enable) begin
            // A rest (pitch 0) never toggles but its duration still runs.
            if (vpitch[c] != '0) begin
              if (tone_cnt[c] == '0) begin
                sq_nx[c]       = ~sq[c];
                tone_cnt_nx[c] = vpitch[c] - 1'b1;
              end else begin
                tone_cnt_nx[c] = tone_cnt[c] - 1'b1;
              end
            end
            if (tick) begin
              if (dur_cnt[c] == DUR_W'(1)) begin
                vstate_nx[c] = V_IDLE;
                sq_nx[c]     = 1'b0;
              end else begin
                dur_cnt_nx[c] = dur_cnt[c] - 1'b1;
              end
            end
          end
        end
        default: vstate_nx[c] = V_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        vstate[c]   <= V_IDLE;
        vpitch[c]   <= '0;
        tone_cnt[c] <= '0;
        dur_cnt[c]  <= '0;
      end
    end else begin
      sq <= sq_nx;
      for (int c = 0; c < CHANNELS; c++) begin
        vstate[c]   <= vstate_nx[c];
        vpitch[c]   <= vpitch_nx[c];
        tone_cnt[c] <= tone_cnt_nx[c];
        dur_cnt[c]  <= dur_cnt_nx[c];
      end
    end
  end

  always_comb begin
    playing = '0;
    level   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      playing[c] = (vstate[c] == V_PLAY);
      level      = level + LVL_W'(sq[c]);
    end
  end

  assign thr  = THR_W'(level) << SHIFT;
  assign busy = fifo_out_vld || (|playing);

  // Threshold only changes at the carrier wrap so each PWM period has one clean duty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      thr_q   <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm <= enable && ({1'b0, pwm_cnt} < thr_q);
      if (enable) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (&pwm_cnt) thr_q <= thr;
      end
    end
  end
endmodule
